prod_accum: RTL and testbench



---
 rtl/prod_accum_if.sv | 38 +++
 rtl/prod_accum.sv | 109 ++++++++++
 tb/tb_prod_accum.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prod_accum_if.sv
// Product/result bus between the multiplier side and prod_accum.
//   master : producer/consumer side (drives clr, len, prod, prod_valid, out_ready)
//   slave  : prod_accum side (drives prod_ready, acc_out, out_valid, ovf, cnt)
// Signals:
//   clr        synchronous frame abort
//   len        products per frame, sampled on the first product of a frame
//   prod       unsigned product, prod_valid/prod_ready handshake
//   acc_out    frame sum, out_valid/out_ready handshake
//   ovf        sticky carry-out of the accumulator for the current frame
//   cnt        products accepted in the current frame
interface prod_accum_if #(
  parameter int PW    = 32,
  parameter int GUARD = 8,
  parameter int LEN_W = 8
);
  localparam int AW = PW + GUARD;

  logic             clr;
  logic [LEN_W-1:0] len;
  logic [PW-1:0]    prod;
  logic             prod_valid;
  logic             prod_ready;
  logic [AW-1:0]    acc_out;
  logic             out_valid;
  logic             out_ready;
  logic             ovf;
  logic [LEN_W-1:0] cnt;

  modport master (
    output clr, len, prod, prod_valid, out_ready,
    input  prod_ready, acc_out, out_valid, ovf, cnt
  );

  modport slave (
    input  clr, len, prod, prod_valid, out_ready,
    output prod_ready, acc_out, out_valid, ovf, cnt
  );
endinterface

// File: rtl/prod_accum.sv
// Frame accumulator for multiplier products (dot-product / MAC datapath).
// Sums a frame of L consecutive unsigned products into an AW = PW+GUARD bit
// register and offers the sum on a valid/ready output.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  prod_accum_if slave modport (product input, result output, clr,
//        len, ovf, cnt)
module prod_accum #(
  parameter int PW    = 32,
  parameter int GUARD = 8,
  parameter int LEN_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  prod_accum_if.slave    bus
);
  localparam int AW = PW + GUARD;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_reg;
  logic [AW-1:0]    acc_reg;
  logic             ovf_reg;
  logic             out_valid_reg;
  logic [LEN_W-1:0] cnt_reg;
  logic [LEN_W-1:0] len_reg;

  logic             accept;
  logic [AW:0]      sum_ext;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] cnt_inc;

  // Ready is decoded from state only, so it never combinationally follows
  // prod_valid or out_ready.
  assign bus.prod_ready = (state_reg != DONE);
  assign accept         = bus.prod_valid && bus.prod_ready;

  // One extra bit captures the carry out of the accumulator.
  assign sum_ext = {1'b0, acc_reg} + (AW+1)'(bus.prod);

  // A zero frame length is treated as a single-product frame.
  assign len_eff = (bus.len == '0) ? LEN_W'(1) : bus.len;
  assign cnt_inc = cnt_reg + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      // clr is a full return to the reset state; any product or result
      // handshake in the same cycle is discarded.
      state_reg     <= IDLE;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      cnt_reg       <= '0;
      len_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            acc_reg <= AW'(bus.prod);
            ovf_reg <= 1'b0;
            cnt_reg <= LEN_W'(1);
            len_reg <= len_eff;
            if (len_eff == LEN_W'(1)) begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end else begin
              state_reg <= ACCUM;
            end
          end
        end

        ACCUM: begin
          if (accept) begin
            acc_reg <= sum_ext[AW-1:0];
            ovf_reg <= ovf_reg | sum_ext[AW];
            cnt_reg <= cnt_inc;
            if (cnt_inc == len_reg) begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end
          end
        end

        DONE: begin
          // prod_ready is low here, so a new frame can only start on the
          // cycle after the result is taken.
          if (out_valid_reg && bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
            cnt_reg       <= '0;
          end
        end

        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.acc_out   = acc_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.cnt       = cnt_reg;
endmodule

// File: tb/tb_prod_accum.sv
module tb_prod_accum;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  prod_accum_if #(.PW(32), .GUARD(8), .LEN_W(8)) pa ();
  prod_accum_if #(.PW(32), .GUARD(0), .LEN_W(8)) pb ();

  prod_accum #(.PW(32), .GUARD(8), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pa)
  );

  prod_accum #(.PW(32), .GUARD(0), .LEN_W(8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (pb)
  );

  typedef struct packed {
    logic [7:0]       len;
    logic [2:0]       n;        // products to send
    logic [3:0][31:0] p;        // products, p[0] first
    logic [3:0][1:0]  gap;      // idle cycles before product i
    logic [39:0]      exp_acc;
    logic [7:0]       exp_cnt;
    logic             exp_ovf;
  } vec_t;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic send_prod(input logic [31:0] p);
    int k;
    pa.prod       = p;
    pa.prod_valid = 1'b1;
    k = 0;
    while (!pa.prod_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 20) check("prod_ready_timeout", 64'(pa.prod_ready), 64'd1);
    @(posedge clk); #1;
    pa.prod_valid = 1'b0;
  endtask

  task automatic release_result(input string tag);
    pa.out_ready = 1'b1;
    @(posedge clk); #1;
    pa.out_ready = 1'b0;
    check({tag, "_rel_valid"}, 64'(pa.out_valid), 64'd0);
    check({tag, "_rel_acc"},   64'(pa.acc_out),   64'd0);
    check({tag, "_rel_cnt"},   64'(pa.cnt),       64'd0);
    check({tag, "_rel_ready"}, 64'(pa.prod_ready), 64'd1);
  endtask

  task automatic run_frame(input vec_t v, input bit do_release, input string tag);
    pa.len = v.len;
    for (int i = 0; i < int'(v.n); i++) begin
      pa.prod_valid = 1'b0;
      for (int g = 0; g < int'(v.gap[i]); g++) begin
        @(posedge clk); #1;
      end
      if (i > 0) check({tag, "_cnt_mid"}, 64'(pa.cnt), 64'(i));
      send_prod(v.p[i]);
      // Later len changes must not affect the running frame.
      if (i == 0) pa.len = 8'($urandom);
    end
    check({tag, "_valid"}, 64'(pa.out_valid),  64'd1);
    check({tag, "_acc"},   64'(pa.acc_out),    64'(v.exp_acc));
    check({tag, "_cnt"},   64'(pa.cnt),        64'(v.exp_cnt));
    check({tag, "_ovf"},   64'(pa.ovf),        64'(v.exp_ovf));
    check({tag, "_ready"}, 64'(pa.prod_ready), 64'd0);
    $display("frame %s len=%0d n=%0d acc=0x%0h cnt=%0d ovf=%0d", tag, v.len, v.n,
             pa.acc_out, pa.cnt, pa.ovf);
    if (do_release) release_result(tag);
  endtask

  // Reference: sum of the frame products in wide arithmetic; the low 40 bits
  // are the wrapped sum and anything above means a carry happened.
  function automatic vec_t make_random();
    vec_t v;
    logic [63:0] sum;
    int l;
    v = '0;
    v.len = 8'($urandom_range(0, 4));
    l = (v.len == 0) ? 1 : int'(v.len);
    v.n = 3'(l);
    sum = 0;
    for (int i = 0; i < l; i++) begin
      v.p[i]   = $urandom;
      v.gap[i] = 2'($urandom_range(0, 2));
      sum += 64'(v.p[i]);
    end
    v.exp_acc = sum[39:0];
    v.exp_ovf = (sum >= 64'h100_0000_0000);
    v.exp_cnt = 8'(l);
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[5];
    vec_t v;

    pa.clr = 0; pa.len = 0; pa.prod = 0; pa.prod_valid = 0; pa.out_ready = 0;
    pb.clr = 0; pb.len = 0; pb.prod = 0; pb.prod_valid = 0; pb.out_ready = 0;

    tbl[0] = '0; tbl[0].len = 8'd4; tbl[0].n = 3'd4;
    tbl[0].p = {32'd4, 32'd3, 32'd2, 32'd1};
    tbl[0].exp_acc = 40'd10; tbl[0].exp_cnt = 8'd4;

    tbl[1] = '0; tbl[1].len = 8'd0; tbl[1].n = 3'd1;
    tbl[1].p[0] = 32'h0000_FFFF;
    tbl[1].exp_acc = 40'h00_0000_FFFF; tbl[1].exp_cnt = 8'd1;

    tbl[2] = '0; tbl[2].len = 8'd3; tbl[2].n = 3'd3;
    tbl[2].p = {32'd0, 32'd9, 32'd7, 32'd5};
    tbl[2].gap = {2'd0, 2'd1, 2'd2, 2'd0};
    tbl[2].exp_acc = 40'd21; tbl[2].exp_cnt = 8'd3;

    tbl[3] = '0; tbl[3].len = 8'd2; tbl[3].n = 3'd2;
    tbl[3].p = {32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[3].exp_acc = 40'h01_FFFF_FFFE; tbl[3].exp_cnt = 8'd2;

    tbl[4] = '0; tbl[4].len = 8'd1; tbl[4].n = 3'd1;
    tbl[4].p[0] = 32'd3;
    tbl[4].exp_acc = 40'd3; tbl[4].exp_cnt = 8'd1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", 64'(pa.out_valid),  64'd0);
    check("rst_acc",   64'(pa.acc_out),    64'd0);
    check("rst_cnt",   64'(pa.cnt),        64'd0);
    check("rst_ovf",   64'(pa.ovf),        64'd0);
    check("rst_ready", 64'(pa.prod_ready), 64'd1);
    check("rst_acc0",  64'(pb.acc_out),    64'd0);

    for (int t = 0; t < 5; t++) run_frame(tbl[t], 1'b1, $sformatf("tbl%0d", t));

    // Held result: stable under out_ready=0 and offered products are refused.
    run_frame(tbl[2], 1'b0, "stall");
    pa.prod = 32'd1000; pa.prod_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("stall_valid", 64'(pa.out_valid),  64'd1);
      check("stall_acc",   64'(pa.acc_out),    64'd21);
      check("stall_cnt",   64'(pa.cnt),        64'd3);
      check("stall_ready", 64'(pa.prod_ready), 64'd0);
    end
    // Product offered during the release cycle must wait one more cycle.
    pa.prod = 32'd77; pa.len = 8'd1; pa.out_ready = 1'b1;
    @(posedge clk); #1;
    pa.out_ready = 1'b0;
    check("hs_valid", 64'(pa.out_valid), 64'd0);
    check("hs_acc",   64'(pa.acc_out),   64'd0);
    check("hs_cnt",   64'(pa.cnt),       64'd0);
    @(posedge clk); #1;
    pa.prod_valid = 1'b0;
    check("next_valid", 64'(pa.out_valid), 64'd1);
    check("next_acc",   64'(pa.acc_out),   64'd77);
    $display("frame next acc=0x%0h", pa.acc_out);
    release_result("next");

    // clr mid-frame discards the concurrent product.
    pa.len = 8'd5;
    send_prod(32'd1);
    send_prod(32'd2);
    check("clr_pre_cnt", 64'(pa.cnt), 64'd2);
    pa.prod = 32'd100; pa.prod_valid = 1'b1; pa.clr = 1'b1;
    @(posedge clk); #1;
    pa.clr = 1'b0; pa.prod_valid = 1'b0;
    check("clr_cnt",   64'(pa.cnt),        64'd0);
    check("clr_acc",   64'(pa.acc_out),    64'd0);
    check("clr_valid", 64'(pa.out_valid),  64'd0);
    check("clr_ready", 64'(pa.prod_ready), 64'd1);
    $display("clr mid-frame cnt=%0d acc=0x%0h", pa.cnt, pa.acc_out);
    v = '0; v.len = 8'd1; v.n = 3'd1; v.p[0] = 32'd9; v.exp_acc = 40'd9; v.exp_cnt = 8'd1;
    run_frame(v, 1'b1, "after_clr");

    // clr while a result is pending drops it.
    v = '0; v.len = 8'd1; v.n = 3'd1; v.p[0] = 32'd5; v.exp_acc = 40'd5; v.exp_cnt = 8'd1;
    run_frame(v, 1'b0, "done_clr");
    pa.clr = 1'b1;
    @(posedge clk); #1;
    pa.clr = 1'b0;
    check("dclr_valid", 64'(pa.out_valid),  64'd0);
    check("dclr_acc",   64'(pa.acc_out),    64'd0);
    check("dclr_ready", 64'(pa.prod_ready), 64'd1);

    // Longest frame: 255 * (2^32-1) = 0xFE_FFFF_FF01, no carry out of 40 bits.
    pa.len = 8'd255;
    for (int i = 0; i < 255; i++) send_prod(32'hFFFF_FFFF);
    check("long_valid", 64'(pa.out_valid), 64'd1);
    check("long_acc",   64'(pa.acc_out),   64'hFE_FFFF_FF01);
    check("long_cnt",   64'(pa.cnt),       64'd255);
    check("long_ovf",   64'(pa.ovf),       64'd0);
    $display("frame long acc=0x%0h cnt=%0d ovf=%0d", pa.acc_out, pa.cnt, pa.ovf);
    release_result("long");

    // Randomized frames against the arithmetic reference.
    for (int r = 0; r < 20; r++) begin
      v = make_random();
      run_frame(v, 1'b1, $sformatf("rnd%0d", r));
    end

    // No guard bits: carry out is visible as ovf and clears on the next frame.
    pb.len = 8'd2; pb.prod = 32'hFFFF_FFFF; pb.prod_valid = 1'b1;
    @(posedge clk); #1;
    pb.prod = 32'h0000_0002;
    @(posedge clk); #1;
    pb.prod_valid = 1'b0;
    check("g0_valid", 64'(pb.out_valid), 64'd1);
    check("g0_acc",   64'(pb.acc_out),   64'h0000_0001);
    check("g0_ovf",   64'(pb.ovf),       64'd1);
    check("g0_cnt",   64'(pb.cnt),       64'd2);
    $display("frame g0 acc=0x%0h ovf=%0d", pb.acc_out, pb.ovf);
    pb.out_ready = 1'b1;
    @(posedge clk); #1;
    pb.out_ready = 1'b0;
    pb.len = 8'd1; pb.prod = 32'd3; pb.prod_valid = 1'b1;
    @(posedge clk); #1;
    pb.prod_valid = 1'b0;
    check("g0b_valid", 64'(pb.out_valid), 64'd1);
    check("g0b_acc",   64'(pb.acc_out),   64'd3);
    check("g0b_ovf",   64'(pb.ovf),       64'd0);
    $display("frame g0b acc=0x%0h ovf=%0d", pb.acc_out, pb.ovf);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
